// File: rtl/mt_pkg.sv
// Shared types and width helpers for the matrix-transpose address path.
// Index widths are derived from matrix/tile dimensions so small sizes still get one bit.
package mt_pkg;

    typedef enum logic {
        MODE_COPY      = 1'b0,
        MODE_TRANSPOSE = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int eb(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int chunk_bytes(input int data_width, input int chunk_size);
        return (data_width / 8) * chunk_size;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tile_index_counter.sv
// Nested ti/tj/r counter for the tile walk; r is innermost, ti outermost.
// Flags are registered from the next-state values so they line up with the counter.
module tile_index_counter
    import mt_pkg::*;
#(
    parameter int CHUNK_SIZE = 4,
    parameter int TILE_ROWS  = 2,
    parameter int TILE_COLS  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_advance,
    output logic o_last_row,
    output logic o_tj_max,
    output logic o_last
);

    localparam int R_W  = idx_width(CHUNK_SIZE);
    localparam int TJ_W = idx_width(TILE_COLS);
    localparam int TI_W = idx_width(TILE_ROWS);

    localparam logic [R_W-1:0]  R_MAX  = R_W'(CHUNK_SIZE - 1);
    localparam logic [TJ_W-1:0] TJ_MAX = TJ_W'(TILE_COLS - 1);
    localparam logic [TI_W-1:0] TI_MAX = TI_W'(TILE_ROWS - 1);

    logic [R_W-1:0]  r_r;
    logic [TJ_W-1:0] r_tj;
    logic [TI_W-1:0] r_ti;
    logic [R_W-1:0]  w_r_next;
    logic [TJ_W-1:0] w_tj_next;
    logic [TI_W-1:0] w_ti_next;
    logic            r_last_row;
    logic            r_tj_max;
    logic            r_last;

    always_comb begin
        w_r_next  = r_r;
        w_tj_next = r_tj;
        w_ti_next = r_ti;
        if (i_clear) begin
            w_r_next  = '0;
            w_tj_next = '0;
            w_ti_next = '0;
        end else if (i_advance) begin
            if (r_r == R_MAX) begin
                w_r_next = '0;
                if (r_tj == TJ_MAX) begin
                    w_tj_next = '0;
                    w_ti_next = (r_ti == TI_MAX) ? '0 : r_ti + TI_W'(1);
                end else begin
                    w_tj_next = r_tj + TJ_W'(1);
                end
            end else begin
                w_r_next = r_r + R_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_r        <= '0;
            r_tj       <= '0;
            r_ti       <= '0;
            r_last_row <= 1'b0;
            r_tj_max   <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            r_r        <= w_r_next;
            r_tj       <= w_tj_next;
            r_ti       <= w_ti_next;
            r_last_row <= (w_r_next == R_MAX);
            r_tj_max   <= (w_tj_next == TJ_MAX);
            r_last     <= (w_r_next == R_MAX) && (w_tj_next == TJ_MAX) && (w_ti_next == TI_MAX);
        end
    end

    assign o_last_row = r_last_row;
    assign o_tj_max   = r_tj_max;
    assign o_last     = r_last;

endmodule

// File: rtl/chunk_addr_gen.sv
// Walks a ROWS x COLS matrix tile by tile and emits one (src, dst) byte-address
// pair per chunk row, in copy or transpose layout, over a valid/ready stream.
module chunk_addr_gen
    import mt_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int ADDR_WIDTH = 64,
    parameter int CHUNK_SIZE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic [ADDR_WIDTH-1:0] src_base,
    input  logic [ADDR_WIDTH-1:0] dst_base,
    output logic                  busy,
    output logic                  done,
    output logic                  req_valid,
    input  logic                  req_ready,
    output logic [ADDR_WIDTH-1:0] req_src_addr,
    output logic [ADDR_WIDTH-1:0] req_dst_addr,
    output logic                  req_last_row,
    output logic                  req_last
);

    localparam int EB = eb(DATA_WIDTH);
    localparam int CB = chunk_bytes(DATA_WIDTH, CHUNK_SIZE);

    // Strides: r steps one matrix row, tj one tile across, ti one tile down.
    localparam logic [ADDR_WIDTH-1:0] SRC_R_STEP  = ADDR_WIDTH'(COLS * EB);
    localparam logic [ADDR_WIDTH-1:0] SRC_TJ_STEP = ADDR_WIDTH'(CB);
    localparam logic [ADDR_WIDTH-1:0] SRC_TI_STEP = ADDR_WIDTH'(CHUNK_SIZE * COLS * EB);
    localparam logic [ADDR_WIDTH-1:0] TR_R_STEP   = ADDR_WIDTH'(ROWS * EB);
    localparam logic [ADDR_WIDTH-1:0] TR_TJ_STEP  = ADDR_WIDTH'(CHUNK_SIZE * ROWS * EB);
    localparam logic [ADDR_WIDTH-1:0] TR_TI_STEP  = ADDR_WIDTH'(CB);

    state_e                r_state;
    mode_e                 r_mode;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_valid;
    logic [ADDR_WIDTH-1:0] r_src_addr;
    logic [ADDR_WIDTH-1:0] r_src_tile;
    logic [ADDR_WIDTH-1:0] r_src_row;
    logic [ADDR_WIDTH-1:0] r_dst_addr;
    logic [ADDR_WIDTH-1:0] r_dst_tile;
    logic [ADDR_WIDTH-1:0] r_dst_row;

    logic                  w_fire;
    logic                  w_launch;
    logic                  w_last_row;
    logic                  w_tj_max;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_dst_r_step;
    logic [ADDR_WIDTH-1:0] w_dst_tj_step;
    logic [ADDR_WIDTH-1:0] w_dst_ti_step;

    assign w_fire   = (r_state == RUN) && r_valid && req_ready;
    assign w_launch = (r_state == IDLE) && start;

    tile_index_counter #(
        .CHUNK_SIZE (CHUNK_SIZE),
        .TILE_ROWS  (ROWS / CHUNK_SIZE),
        .TILE_COLS  (COLS / CHUNK_SIZE)
    ) u_idx (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_launch),
        .i_advance  (w_fire),
        .o_last_row (w_last_row),
        .o_tj_max   (w_tj_max),
        .o_last     (w_last)
    );

    always_comb begin
        w_dst_r_step  = SRC_R_STEP;
        w_dst_tj_step = SRC_TJ_STEP;
        w_dst_ti_step = SRC_TI_STEP;
        if (r_mode == MODE_TRANSPOSE) begin
            w_dst_r_step  = TR_R_STEP;
            w_dst_tj_step = TR_TJ_STEP;
            w_dst_ti_step = TR_TI_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_mode     <= MODE_COPY;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_valid    <= 1'b0;
            r_src_addr <= '0;
            r_src_tile <= '0;
            r_src_row  <= '0;
            r_dst_addr <= '0;
            r_dst_tile <= '0;
            r_dst_row  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state    <= RUN;
                        r_mode     <= mode_e'(mode);
                        r_busy     <= 1'b1;
                        r_valid    <= 1'b1;
                        r_src_addr <= src_base;
                        r_src_tile <= src_base;
                        r_src_row  <= src_base;
                        r_dst_addr <= dst_base;
                        r_dst_tile <= dst_base;
                        r_dst_row  <= dst_base;
                    end
                end
                RUN: begin
                    if (w_fire) begin
                        if (w_last) begin
                            r_state <= DONE;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (!w_last_row) begin
                            r_src_addr <= r_src_addr + SRC_R_STEP;
                            r_dst_addr <= r_dst_addr + w_dst_r_step;
                        end else if (!w_tj_max) begin
                            r_src_tile <= r_src_tile + SRC_TJ_STEP;
                            r_src_addr <= r_src_tile + SRC_TJ_STEP;
                            r_dst_tile <= r_dst_tile + w_dst_tj_step;
                            r_dst_addr <= r_dst_tile + w_dst_tj_step;
                        end else begin
                            // Row of tiles finished: restart from the next tile-row base.
                            r_src_row  <= r_src_row + SRC_TI_STEP;
                            r_src_tile <= r_src_row + SRC_TI_STEP;
                            r_src_addr <= r_src_row + SRC_TI_STEP;
                            r_dst_row  <= r_dst_row + w_dst_ti_step;
                            r_dst_tile <= r_dst_row + w_dst_ti_step;
                            r_dst_addr <= r_dst_row + w_dst_ti_step;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign req_valid    = r_valid;
    assign req_src_addr = r_src_addr;
    assign req_dst_addr = r_dst_addr;
    assign req_last_row = w_last_row;
    assign req_last     = w_last;

endmodule

// File: tb/tb_chunk_addr_gen.sv
// Self-checking bench: a square 8x8 and a rectangular 4x8 instance, checked
// against a nested-loop model of the address formulas plus a table of known pairs.
module tb_chunk_addr_gen;

    localparam int AW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic          req_ready = 1'b0;
    logic          sel = 1'b0;
    logic [AW-1:0] src_base = '0;
    logic [AW-1:0] dst_base = '0;

    logic          a_start, a_busy, a_done, a_valid, a_lr, a_last;
    logic          b_start, b_busy, b_done, b_valid, b_lr, b_last;
    logic [AW-1:0] a_src, a_dst, b_src, b_dst;
    logic          m_busy, m_done, m_valid, m_lr, m_last;
    logic [AW-1:0] m_src, m_dst;

    assign a_start = start & ~sel;
    assign b_start = start & sel;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_done  = sel ? b_done  : a_done;
    assign m_valid = sel ? b_valid : a_valid;
    assign m_lr    = sel ? b_lr    : a_lr;
    assign m_last  = sel ? b_last  : a_last;
    assign m_src   = sel ? b_src   : a_src;
    assign m_dst   = sel ? b_dst   : a_dst;

    always #5 clk = ~clk;

    chunk_addr_gen #(
        .DATA_WIDTH(64), .ROWS(8), .COLS(8), .ADDR_WIDTH(AW), .CHUNK_SIZE(4)
    ) u_sq (
        .clk(clk), .rst(rst), .start(a_start), .mode(mode),
        .src_base(src_base), .dst_base(dst_base),
        .busy(a_busy), .done(a_done), .req_valid(a_valid), .req_ready(req_ready),
        .req_src_addr(a_src), .req_dst_addr(a_dst),
        .req_last_row(a_lr), .req_last(a_last)
    );

    chunk_addr_gen #(
        .DATA_WIDTH(64), .ROWS(4), .COLS(8), .ADDR_WIDTH(AW), .CHUNK_SIZE(4)
    ) u_rect (
        .clk(clk), .rst(rst), .start(b_start), .mode(mode),
        .src_base(src_base), .dst_base(dst_base),
        .busy(b_busy), .done(b_done), .req_valid(b_valid), .req_ready(req_ready),
        .req_src_addr(b_src), .req_dst_addr(b_dst),
        .req_last_row(b_lr), .req_last(b_last)
    );

    typedef struct {
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic          lr;
        logic          last;
    } req_t;

    typedef struct {
        bit            rect;
        bit            md;
        logic [AW-1:0] sb;
        logic [AW-1:0] db;
        int            idx;
        logic [AW-1:0] esrc;
        logic [AW-1:0] edst;
    } vec_t;

    req_t exp_q[$];
    req_t obs_q[$];
    vec_t vecs[8];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: visit order and byte addresses straight from the index formulas.
    task automatic build_model(input int rows, input int cols, input bit md,
                               input logic [AW-1:0] sb, input logic [AW-1:0] db);
        req_t e;
        exp_q.delete();
        for (int ti = 0; ti < rows / 4; ti++)
            for (int tj = 0; tj < cols / 4; tj++)
                for (int r = 0; r < 4; r++) begin
                    e.src  = sb + AW'(((ti * 4 + r) * cols + tj * 4) * 8);
                    e.dst  = md ? db + AW'(((tj * 4 + r) * rows + ti * 4) * 8)
                                : db + AW'(((ti * 4 + r) * cols + tj * 4) * 8);
                    e.lr   = (r == 3);
                    e.last = (r == 3) && (ti == rows / 4 - 1) && (tj == cols / 4 - 1);
                    exp_q.push_back(e);
                end
    endtask

    task automatic run_job(input bit rect, input bit md, input logic [AW-1:0] sb,
                           input logic [AW-1:0] db, input int stall_pct,
                           input bit spam, input int abort_at);
        int   n, k, cyc;
        bit   rdy, prev_stall;
        req_t prev, o;
        sel = rect;
        build_model(rect ? 4 : 8, 8, md, sb, db);
        n = exp_q.size();
        obs_q.delete();
        @(negedge clk);
        start = 1'b1; mode = md; src_base = sb; dst_base = db; req_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0; cyc = 0; prev_stall = 1'b0;
        prev = '{src: '0, dst: '0, lr: 1'b0, last: 1'b0};
        while (k < n && cyc < 2000) begin
            if (prev_stall) begin
                chk("stall_valid", AW'(m_valid), 1);
                chk("stall_src", m_src, prev.src);
                chk("stall_dst", m_dst, prev.dst);
                chk("stall_flags", AW'({m_lr, m_last}), AW'({prev.lr, prev.last}));
            end
            rdy = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
            req_ready = rdy;
            if (spam) begin
                start = ($urandom_range(1) == 1);
                mode = ($urandom_range(1) == 1);
                src_base = {$urandom, $urandom};
                dst_base = {$urandom, $urandom};
            end
            if (m_valid && rdy) begin
                o = '{src: m_src, dst: m_dst, lr: m_lr, last: m_last};
                $display("req %0d: src=0x%0h dst=0x%0h last_row=%0b last=%0b",
                         k, o.src, o.dst, o.lr, o.last);
                chk("req_src", o.src, exp_q[k].src);
                chk("req_dst", o.dst, exp_q[k].dst);
                chk("req_last_row", AW'(o.lr), AW'(exp_q[k].lr));
                chk("req_last", AW'(o.last), AW'(exp_q[k].last));
                obs_q.push_back(o);
                k++;
                if (abort_at > 0 && k == abort_at) begin
                    rst = 1'b1;
                    start = 1'b0;
                    return;
                end
            end
            prev_stall = m_valid && !rdy;
            prev = '{src: m_src, dst: m_dst, lr: m_lr, last: m_last};
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        req_ready = 1'b1;
        chk("req_count", AW'(k), AW'(n));
        if (stall_pct == 0) chk("back_to_back_cycles", AW'(cyc), AW'(n));
        chk("done_pulse", AW'(m_done), 1);
        chk("valid_after_last", AW'(m_valid), 0);
        chk("busy_in_done", AW'(m_busy), 1);
        @(negedge clk);
        chk("done_cleared", AW'(m_done), 0);
        chk("busy_cleared", AW'(m_busy), 0);
    endtask

    initial begin
        int dones;

        vecs[0] = '{rect: 0, md: 1, sb: 64'h1000, db: 64'h2000, idx: 0,  esrc: 64'h1000, edst: 64'h2000};
        vecs[1] = '{rect: 0, md: 1, sb: 64'h1000, db: 64'h2000, idx: 1,  esrc: 64'h1040, edst: 64'h2040};
        vecs[2] = '{rect: 0, md: 1, sb: 64'h1000, db: 64'h2000, idx: 4,  esrc: 64'h1020, edst: 64'h2100};
        vecs[3] = '{rect: 0, md: 1, sb: 64'h1000, db: 64'h2000, idx: 8,  esrc: 64'h1100, edst: 64'h2020};
        vecs[4] = '{rect: 0, md: 1, sb: 64'h1000, db: 64'h2000, idx: 15, esrc: 64'h11E0, edst: 64'h21E0};
        vecs[5] = '{rect: 1, md: 1, sb: 64'h0,    db: 64'h0,    idx: 6,  esrc: 64'hA0,   edst: 64'hC0};
        vecs[6] = '{rect: 0, md: 0, sb: 64'hFFFF_FFFF_FFFF_FFC0, db: 64'h0, idx: 1, esrc: 64'h0, edst: 64'h40};
        vecs[7] = '{rect: 0, md: 0, sb: 64'h1000, db: 64'h2000, idx: 5,  esrc: 64'h1060, edst: 64'h2060};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", AW'(a_busy), 0);
        chk("rst_done", AW'(a_done), 0);
        chk("rst_valid", AW'(a_valid), 0);
        chk("rst_src", a_src, 0);
        chk("rst_dst", a_dst, 0);
        chk("rst_flags", AW'({a_lr, a_last}), 0);

        for (int i = 0; i < 8; i++) begin
            run_job(vecs[i].rect, vecs[i].md, vecs[i].sb, vecs[i].db, 0, 1'b0, 0);
            chk("vec_src", obs_q[vecs[i].idx].src, vecs[i].esrc);
            chk("vec_dst", obs_q[vecs[i].idx].dst, vecs[i].edst);
        end

        run_job(1'b0, 1'b0, 64'h1000, 64'h2000, 0, 1'b0, 0);
        for (int i = 0; i < obs_q.size(); i++)
            chk("copy_dst_offset", obs_q[i].dst, obs_q[i].src + 64'h1000);

        for (int j = 0; j < 6; j++)
            run_job(j[0], j[1], {$urandom, $urandom}, {$urandom, $urandom}, 40, 1'b1, 0);

        run_job(1'b0, 1'b1, 64'h1000, 64'h2000, 0, 1'b0, 5);
        @(negedge clk);
        chk("abort_busy", AW'(a_busy), 0);
        chk("abort_done", AW'(a_done), 0);
        chk("abort_valid", AW'(a_valid), 0);
        chk("abort_src", a_src, 0);
        chk("abort_dst", a_dst, 0);
        chk("abort_flags", AW'({a_lr, a_last}), 0);
        rst = 1'b0;
        dones = 0;
        repeat (4) begin
            @(negedge clk);
            if (a_done) dones++;
        end
        chk("abort_no_done", AW'(dones), 0);
        run_job(1'b0, 1'b1, 64'h1000, 64'h2000, 0, 1'b0, 0);
        chk("replay_first_src", obs_q[0].src, 64'h1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
